// File: rtl/inst_mem_responder.sv
// Instruction memory responder: returns the words at Address and Address+4 LATENCY cycles after a request.
// Define IMEM_MISALIGN_CHECK_EN to add the Misalign output and misaligned-request reporting.
//
// state | meaning
// IDLE  | no request outstanding, accepting requests
// WAIT  | request latched, latency counter running (Busy high)
// RESP  | response on Inst1/Inst2 for one cycle, accepting a new request
module inst_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Flush,
    input  logic [32:0] Req_i,
    output logic [32:0] Inst1,
    output logic [32:0] Inst2,
    output logic        Busy,
    input  logic        Load_En,
    input  logic [31:0] Load_Addr,
    input  logic [31:0] Load_Data
`ifdef IMEM_MISALIGN_CHECK_EN
    ,
    output logic        Misalign
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};
    localparam logic [AW-1:0] ONE_IDX = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [AW-1:0] idx_q, rd_idx, rd_idx_nx;
    logic [31:0]   req_addr;
    logic          req_valid;
    logic [AW-1:0] req_idx;
    logic          accept;
    logic [32:0]   inst1_n, inst2_n;
    logic          busy_n;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          unused_addr_bits;

    assign req_addr  = Req_i[32:1];
    assign req_valid = Req_i[0];
    assign req_idx   = req_addr[AW+1:2];
    assign accept    = req_valid && !Flush && (state == IDLE || state == RESP);
    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0], Load_Addr[31:AW+2], Load_Addr[1:0]};

`ifdef IMEM_MISALIGN_CHECK_EN
    logic mis_q, rd_mis, misalign_n;
`endif

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            idx_q <= '0;
            Inst1 <= '0;
            Inst2 <= '0;
            Busy  <= 1'b0;
`ifdef IMEM_MISALIGN_CHECK_EN
            mis_q    <= 1'b0;
            Misalign <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                idx_q <= req_idx;
            end
            Inst1 <= inst1_n;
            Inst2 <= inst2_n;
            Busy  <= busy_n;
`ifdef IMEM_MISALIGN_CHECK_EN
            if (accept) begin
                mis_q <= (req_addr[1:0] != 2'b00);
            end
            Misalign <= misalign_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (Flush) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE, RESP: begin
                    state_n = IDLE;
                    if (accept) begin
                        if (LATENCY == 1) begin
                            state_n = RESP;
                        end else begin
                            state_n = WAIT;
                            cnt_n   = CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state_n = RESP;
                    end else begin
                        cnt_n = cnt - 4'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // With LATENCY=1 the read happens on the accepting edge, so bypass the latched index.
    always_comb begin
        rd_idx    = accept ? req_idx : idx_q;
        rd_idx_nx = rd_idx + ONE_IDX;
        inst1_n   = '0;
        inst2_n   = '0;
        busy_n    = (state_n == WAIT);
        if (state_n == RESP) begin
            inst1_n = {mem[rd_idx], 1'b1};
            if (rd_idx != LAST_IDX) begin
                inst2_n = {mem[rd_idx_nx], 1'b1};
            end
        end
`ifdef IMEM_MISALIGN_CHECK_EN
        rd_mis     = accept ? (req_addr[1:0] != 2'b00) : mis_q;
        misalign_n = 1'b0;
        if (state_n == RESP && rd_mis) begin
            inst1_n    = {32'd0, 1'b1};
            inst2_n    = '0;
            misalign_n = 1'b1;
        end
`endif
    end

    // Contents survive reset; a same-edge read sees the old word.
    always_ff @(posedge Clk) begin
        if (Load_En) begin
            mem[Load_Addr[AW+1:2]] <= Load_Data;
        end
    end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Self-checking bench for inst_mem_responder: due-time reference model plus directed literal checks.
// Honours IMEM_MISALIGN_CHECK_EN when the design is built with it.
module tb_inst_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Flush = 1'b0;
    logic [32:0] Req_i = '0;
    logic [32:0] Inst1, Inst2;
    logic        Busy;
    logic        Load_En = 1'b0;
    logic [31:0] Load_Addr = '0;
    logic [31:0] Load_Data = '0;
`ifdef IMEM_MISALIGN_CHECK_EN
    logic        Misalign;
`endif

    inst_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .Clk(Clk), .Rst(Rst), .Flush(Flush), .Req_i(Req_i),
        .Inst1(Inst1), .Inst2(Inst2), .Busy(Busy),
        .Load_En(Load_En), .Load_Addr(Load_Addr), .Load_Data(Load_Data)
`ifdef IMEM_MISALIGN_CHECK_EN
        , .Misalign(Misalign)
`endif
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a pending request is answered at a known edge number.
    logic [31:0] mmem [DEPTH];
    logic        pend = 1'b0;
    int          pend_due = 0;
    logic [31:0] pend_addr = '0;
    int          edge_n = 0;
    logic        started = 1'b0;
    logic [32:0] exp1 = '0, exp2 = '0;
    logic        expb = 1'b0, expm = 1'b0;
    logic [32:0] n1, n2;
    logic        nm_bit;
    logic [9:0]  midx;

    always @(posedge Clk) begin
        n1 = '0; n2 = '0; nm_bit = 1'b0;
        if (!Rst || Flush) begin
            pend = 1'b0;
        end else begin
            if (!pend && Req_i[0]) begin
                pend      = 1'b1;
                pend_due  = edge_n + LAT - 1;
                pend_addr = Req_i[32:1];
            end
            if (pend && pend_due == edge_n) begin
                midx = pend_addr[11:2];
                n1 = {mmem[midx], 1'b1};
                if (midx != 10'(DEPTH - 1)) n2 = {mmem[midx + 10'd1], 1'b1};
`ifdef IMEM_MISALIGN_CHECK_EN
                if (pend_addr[1:0] != 2'b00) begin
                    n1 = {32'd0, 1'b1};
                    n2 = '0;
                    nm_bit = 1'b1;
                end
`endif
                pend = 1'b0;
            end
        end
        if (Load_En) mmem[Load_Addr[11:2]] = Load_Data;
        exp1 = n1; exp2 = n2; expb = pend; expm = nm_bit;
        edge_n++;
        started = 1'b1;
    end

    always @(negedge Clk) begin
        if (started) begin
            check("model_inst1", Inst1, exp1);
            check("model_inst2", Inst2, exp2);
            check("model_busy", {32'd0, Busy}, {32'd0, expb});
`ifdef IMEM_MISALIGN_CHECK_EN
            check("model_misalign", {32'd0, Misalign}, {32'd0, expm});
`endif
        end
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic idle_inputs();
        Req_i = '0; Flush = 1'b0; Load_En = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        Load_En = 1'b1; Load_Addr = a; Load_Data = d;
        tick();
        Load_En = 1'b0;
    endtask

    task automatic basic_req(input string tag);
        Req_i = {32'h10, 1'b1};
        tick();
        idle_inputs();
        @(negedge Clk);
        check({tag, "_busy"}, {32'd0, Busy}, 33'd1);
        check({tag, "_wait_inst1"}, Inst1, 33'd0);
        @(negedge Clk);
        check({tag, "_inst1"}, Inst1, {32'h11111111, 1'b1});
        check({tag, "_inst2"}, Inst2, {32'h22222222, 1'b1});
        check({tag, "_busy_resp"}, {32'd0, Busy}, 33'd0);
        @(negedge Clk);
        check({tag, "_after_inst1"}, Inst1, 33'd0);
        tick();
    endtask

    logic [31:0] ra, la;
    logic        rq;
    logic [9:0]  last_idx = '0;

    initial begin
        // Preload every word while held in reset.
        for (int i = 0; i < DEPTH; i++) begin
            ra = $urandom;
            la = {ra[31:12], 10'(i), ra[1:0]};
            Load_En = 1'b1; Load_Addr = la; Load_Data = $urandom;
            tick();
        end
        load_word(32'h10, 32'h11111111);
        load_word(32'h14, 32'h22222222);
        load_word(32'h20, 32'h33333333);
        load_word(32'h24, 32'h44444444);
        load_word(32'hFFC, 32'hDEADBEEF);
        @(negedge Clk);
        check("reset_inst1", Inst1, 33'd0);
        check("reset_inst2", Inst2, 33'd0);
        check("reset_busy", {32'd0, Busy}, 33'd0);
        Rst = 1'b1;
        tick();

        basic_req("basic");

        // Back-to-back with a request presented during WAIT.
        Req_i = {32'h10, 1'b1};
        tick();
        Req_i = {32'h20, 1'b1};
        @(negedge Clk);
        check("b2b_busy1", {32'd0, Busy}, 33'd1);
        @(negedge Clk);
        check("b2b_first", Inst1, {32'h11111111, 1'b1});
        tick();
        idle_inputs();
        @(negedge Clk);
        check("b2b_busy2", {32'd0, Busy}, 33'd1);
        check("b2b_gap", Inst1, 33'd0);
        @(negedge Clk);
        check("b2b_second1", Inst1, {32'h33333333, 1'b1});
        check("b2b_second2", Inst2, {32'h44444444, 1'b1});
        tick(); tick();

        // Flush on the cycle after acceptance.
        Req_i = {32'h10, 1'b1};
        tick();
        Req_i = '0; Flush = 1'b1;
        tick();
        Flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("flush_no_ready", {Inst1[0], Inst2[0], Busy}, 33'd0);
        end
        tick();

        // Request and Flush together.
        Req_i = {32'h10, 1'b1}; Flush = 1'b1;
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("reqflush_no_ready", {Inst1[0], Inst2[0], Busy}, 33'd0);
        end
        tick();

        // Block end.
        Req_i = {32'hFFC, 1'b1};
        tick();
        idle_inputs();
        @(negedge Clk);
        @(negedge Clk);
        check("blockend_inst1", Inst1, {32'hDEADBEEF, 1'b1});
        check("blockend_inst2", Inst2, 33'd0);
        tick();

        // Reset during WAIT.
        Req_i = {32'h10, 1'b1};
        tick();
        Req_i = '0; Rst = 1'b0;
        tick();
        Rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("rst_mid_zero", {Inst1[0], Inst2[0], Busy}, 33'd0);
            check("rst_mid_data", Inst1, 33'd0);
        end
        tick();
        basic_req("post_reset");

        // Misaligned request.
        Req_i = {32'h12, 1'b1};
        tick();
        idle_inputs();
        @(negedge Clk);
        @(negedge Clk);
`ifdef IMEM_MISALIGN_CHECK_EN
        check("mis_inst1", Inst1, {32'd0, 1'b1});
        check("mis_inst2", Inst2, 33'd0);
        check("mis_flag", {32'd0, Misalign}, 33'd1);
`else
        check("mis_inst1", Inst1, {32'h11111111, 1'b1});
        check("mis_inst2", Inst2, {32'h22222222, 1'b1});
`endif
        tick(); tick();

        // Randomized traffic, loads aimed near the last requested word to hit same-edge collisions.
        for (int c = 0; c < 3000; c++) begin
            Rst   = ($urandom_range(0, 99) >= 2);
            Flush = ($urandom_range(0, 99) < 4);
            rq    = ($urandom_range(0, 99) < 60);
            ra    = $urandom;
            if ($urandom_range(0, 9) == 0) ra[11:2] = 10'h3FF;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            Req_i = {ra, rq};
            if (rq) last_idx = ra[11:2];
            la = $urandom;
            la[11:2] = last_idx + 10'($urandom_range(0, 1));
            Load_En   = ($urandom_range(0, 99) < 25);
            Load_Addr = la;
            Load_Data = $urandom;
            tick();
        end
        idle_inputs();
        Rst = 1'b1;
        tick(); tick(); tick();
        @(negedge Clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
